// File: rtl/uart_receiver.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | uart_receiver : 16x-oversampled UART receive path with a one-entry hold  |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module uart_receiver (
  input  logic       clk,
  input  logic       wb_rst_i,
  input  logic [7:0] lcr,
  input  logic       enable,
  input  logic       srx_pad_i,
  input  logic       rd,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       parity_error,
  output logic       framing_error,
  output logic       break_int,
  output logic       overrun,
  output logic [2:0] rstate
);

  typedef enum logic [2:0] {
    R_IDLE       = 3'd0,
    R_REC_START  = 3'd1,
    R_REC_BIT    = 3'd2,
    R_REC_PARITY = 3'd3,
    R_REC_STOP   = 3'd4,
    R_PUSH       = 3'd5,
    R_WAIT_IDLE  = 3'd6
  } state_t;

  state_t     state_q, state_d;
  logic       srx_s1_q, srx_s2_q;
  logic [3:0] cnt_q, cnt_d;
  logic [2:0] bits_q, bits_d;
  logic [7:0] shift_q, shift_d;
  logic       acc_q, acc_d;
  logic       zero_q, zero_d;
  logic       pe_q, pe_d;
  logic       fe_q, fe_d;
  logic       brk_q, brk_d;
  logic [1:0] wlen_q, wlen_d;
  logic       par_en_q, par_en_d;
  logic       even_q, even_d;
  logic       stick_q, stick_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic       perr_q, perr_d;
  logic       ferr_q, ferr_d;
  logic       brk_out_q, brk_out_d;
  logic       ovr_q, ovr_d;
  logic       srx;
  logic       exp_par;
  logic       unused_lcr;

  assign srx        = srx_s2_q;
  assign unused_lcr = ^{lcr[7:6], lcr[2]};

  always_comb begin
    exp_par = 1'b0;
    case ({even_q, stick_q})
      2'b00:   exp_par = ~acc_q;
      2'b10:   exp_par = acc_q;
      2'b01:   exp_par = 1'b1;
      default: exp_par = 1'b0;
    endcase
  end

  // Frame-level settings are captured at the start sample so a mid-character
  // lcr write only affects the following frame.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bits_d   = bits_q;
    shift_d  = shift_q;
    acc_d    = acc_q;
    zero_d   = zero_q;
    pe_d     = pe_q;
    fe_d     = fe_q;
    brk_d    = brk_q;
    wlen_d   = wlen_q;
    par_en_d = par_en_q;
    even_d   = even_q;
    stick_d  = stick_q;
    case (state_q)
      R_IDLE: begin
        if (enable && !srx) begin
          cnt_d   = 4'd7;
          state_d = R_REC_START;
        end
      end
      R_REC_START: begin
        if (enable) begin
          if (cnt_q == 4'd0) begin
            if (srx) begin
              state_d = R_IDLE;
            end else begin
              cnt_d    = 4'd15;
              shift_d  = 8'd0;
              acc_d    = 1'b0;
              zero_d   = 1'b1;
              pe_d     = 1'b0;
              bits_d   = {1'b1, lcr[1:0]};
              wlen_d   = lcr[1:0];
              par_en_d = lcr[3];
              even_d   = lcr[4];
              stick_d  = lcr[5];
              state_d  = R_REC_BIT;
            end
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
      end
      R_REC_BIT: begin
        if (enable) begin
          if (cnt_q == 4'd0) begin
            shift_d = {srx, shift_q[7:1]};
            acc_d   = acc_q ^ srx;
            zero_d  = zero_q & ~srx;
            cnt_d   = 4'd15;
            if (bits_q != 3'd0) begin
              bits_d = bits_q - 3'd1;
            end else begin
              state_d = par_en_q ? R_REC_PARITY : R_REC_STOP;
            end
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
      end
      R_REC_PARITY: begin
        if (enable) begin
          if (cnt_q == 4'd0) begin
            pe_d    = (srx != exp_par);
            zero_d  = zero_q & ~srx;
            cnt_d   = 4'd15;
            state_d = R_REC_STOP;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
      end
      R_REC_STOP: begin
        if (enable) begin
          if (cnt_q == 4'd0) begin
            fe_d    = ~srx;
            brk_d   = zero_q & ~srx;
            state_d = R_PUSH;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
      end
      R_PUSH: begin
        state_d = fe_q ? R_WAIT_IDLE : R_IDLE;
      end
      R_WAIT_IDLE: begin
        if (srx) begin
          state_d = R_IDLE;
        end
      end
      default: begin
        state_d = R_IDLE;
      end
    endcase
  end

  // Shift register fills from bit 7 downwards, so short words need a right
  // alignment of (8 - length) positions before they land in the holding reg.
  always_comb begin
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q;
    perr_d     = perr_q;
    ferr_d     = ferr_q;
    brk_out_d  = brk_out_q;
    ovr_d      = ovr_q;
    if (state_q == R_PUSH) begin
      if (!rx_valid_q || rd) begin
        rx_data_d  = shift_q >> (2'd3 - wlen_q);
        rx_valid_d = 1'b1;
        perr_d     = pe_q & par_en_q;
        ferr_d     = fe_q;
        brk_out_d  = brk_q;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (rd && rx_valid_q) begin
      rx_valid_d = 1'b0;
      perr_d     = 1'b0;
      ferr_d     = 1'b0;
      brk_out_d  = 1'b0;
      ovr_d      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!wb_rst_i) begin
      state_q    <= R_IDLE;
      srx_s1_q   <= 1'b1;
      srx_s2_q   <= 1'b1;
      cnt_q      <= 4'd0;
      bits_q     <= 3'd0;
      shift_q    <= 8'd0;
      acc_q      <= 1'b0;
      zero_q     <= 1'b0;
      pe_q       <= 1'b0;
      fe_q       <= 1'b0;
      brk_q      <= 1'b0;
      wlen_q     <= 2'd0;
      par_en_q   <= 1'b0;
      even_q     <= 1'b0;
      stick_q    <= 1'b0;
      rx_data_q  <= 8'd0;
      rx_valid_q <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      brk_out_q  <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      srx_s1_q   <= srx_pad_i;
      srx_s2_q   <= srx_s1_q;
      cnt_q      <= cnt_d;
      bits_q     <= bits_d;
      shift_q    <= shift_d;
      acc_q      <= acc_d;
      zero_q     <= zero_d;
      pe_q       <= pe_d;
      fe_q       <= fe_d;
      brk_q      <= brk_d;
      wlen_q     <= wlen_d;
      par_en_q   <= par_en_d;
      even_q     <= even_d;
      stick_q    <= stick_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      brk_out_q  <= brk_out_d;
      ovr_q      <= ovr_d;
    end
  end

  assign rx_data       = rx_data_q;
  assign rx_valid      = rx_valid_q;
  assign parity_error  = perr_q;
  assign framing_error = ferr_q;
  assign break_int     = brk_out_q;
  assign overrun       = ovr_q;
  assign rstate        = state_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_receiver.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_uart_receiver : directed frames against a tick-arithmetic line model  |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_uart_receiver;

  localparam int DIV      = 3;
  localparam int BIT_CLKS = 16 * DIV;
  localparam int M_IDLE   = 0;
  localparam int M_FRAME  = 1;
  localparam int M_PUSH   = 2;
  localparam int M_WAIT   = 3;

  logic       clk = 1'b0;
  logic       wb_rst_i;
  logic [7:0] lcr;
  logic       enable;
  logic       srx_pad_i;
  logic       rd;
  logic [7:0] rx_data;
  logic       rx_valid, parity_error, framing_error, break_int, overrun;
  logic [2:0] rstate;

  int checks = 0;
  int errors = 0;
  bit m_on   = 1'b0;

  uart_receiver dut (
    .clk           (clk),
    .wb_rst_i      (wb_rst_i),
    .lcr           (lcr),
    .enable        (enable),
    .srx_pad_i     (srx_pad_i),
    .rd            (rd),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .parity_error  (parity_error),
    .framing_error (framing_error),
    .break_int     (break_int),
    .overrun       (overrun),
    .rstate        (rstate)
  );

  always #5 clk = ~clk;

  initial begin
    enable = 1'b0;
    forever begin
      repeat (DIV - 1) @(negedge clk);
      enable = 1'b1;
      @(negedge clk);
      enable = 1'b0;
    end
  end

  // Line model: samples fall at ticks 8 + 16*k after the tick that first saw
  // the line low; sample 0 is the start bit, then data, optional parity, stop.
  int          m_phase;
  int          m_t;
  int          m_k;
  int          m_nb;
  bit          m_pen;
  logic [1:0]  m_pmode;
  logic [11:0] m_bits;
  logic        m_s1, m_s2;
  logic [7:0]  p_data;
  logic        p_pe, p_fe, p_brk;
  logic [7:0]  e_data;
  logic        e_valid, e_pe, e_fe, e_brk, e_ovr;

  function automatic logic [7:0] char_of(input logic [11:0] b, input int nb);
    logic [7:0] v = 8'd0;
    for (int i = 0; i < nb; i++) v[i] = b[i+1];
    return v;
  endfunction

  function automatic logic exp_par(input logic [11:0] b, input int nb, input logic [1:0] pm);
    logic ones = 1'b0;
    for (int i = 0; i < nb; i++) ones = ones ^ b[i+1];
    case (pm)
      2'b00:   return ~ones;
      2'b10:   return ones;
      2'b01:   return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [2:0] exp_state();
    if (m_phase == M_PUSH) return 3'd5;
    if (m_phase == M_WAIT) return 3'd6;
    if (m_phase == M_IDLE) return 3'd0;
    if (m_k == 0) return 3'd1;
    if (m_k <= m_nb) return 3'd2;
    if (m_pen && m_k == m_nb + 1) return 3'd3;
    return 3'd4;
  endfunction

  always @(posedge clk) begin
    if (!wb_rst_i) begin
      m_phase <= M_IDLE;
      m_t     <= 0;
      m_k     <= 0;
      m_nb    <= 8;
      m_pen   <= 1'b0;
      m_pmode <= 2'b00;
      m_bits  <= 12'd0;
      m_s1    <= 1'b1;
      m_s2    <= 1'b1;
      e_data  <= 8'd0;
      e_valid <= 1'b0;
      e_pe    <= 1'b0;
      e_fe    <= 1'b0;
      e_brk   <= 1'b0;
      e_ovr   <= 1'b0;
    end else begin
      m_s1 <= srx_pad_i;
      m_s2 <= m_s1;
      if (m_phase == M_PUSH) begin
        if (!e_valid || rd) begin
          e_valid <= 1'b1;
          e_data  <= p_data;
          e_pe    <= p_pe;
          e_fe    <= p_fe;
          e_brk   <= p_brk;
        end else begin
          e_ovr <= 1'b1;
        end
        m_phase <= p_fe ? M_WAIT : M_IDLE;
      end else if (rd && e_valid) begin
        e_valid <= 1'b0;
        e_pe    <= 1'b0;
        e_fe    <= 1'b0;
        e_brk   <= 1'b0;
        e_ovr   <= 1'b0;
      end
      case (m_phase)
        M_IDLE: begin
          if (enable && !m_s2) begin
            m_phase <= M_FRAME;
            m_t     <= 0;
            m_k     <= 0;
            m_bits  <= 12'd0;
          end
        end
        M_FRAME: begin
          if (enable) begin
            m_t <= m_t + 1;
            if (m_t + 1 == 8 + 16 * m_k) begin
              if (m_k == 0) begin
                if (m_s2) begin
                  m_phase <= M_IDLE;
                end else begin
                  m_nb    <= 5 + int'(lcr[1:0]);
                  m_pen   <= lcr[3];
                  m_pmode <= {lcr[4], lcr[5]};
                  m_k     <= 1;
                end
              end else begin
                m_bits[m_k] <= m_s2;
                m_k         <= m_k + 1;
                if (m_k == m_nb + (m_pen ? 1 : 0) + 1) begin
                  p_data  <= char_of(m_bits, m_nb);
                  p_pe    <= m_pen && (m_bits[m_nb+1] != exp_par(m_bits, m_nb, m_pmode));
                  p_fe    <= !m_s2;
                  p_brk   <= !m_s2 && (m_bits == 12'd0);
                  m_phase <= M_PUSH;
                end
              end
            end
          end
        end
        M_WAIT: begin
          if (m_s2) m_phase <= M_IDLE;
        end
        default: ;
      endcase
    end
  end

  always @(negedge clk) begin
    if (m_on) begin
      checks++;
      if ({rx_valid, rx_data, parity_error, framing_error, break_int, overrun, rstate} !==
          {e_valid, e_data, e_pe, e_fe, e_brk, e_ovr, exp_state()}) begin
        errors++;
        $display("FAIL cycle_model t=%0t got v=%b d=%h pe=%b fe=%b brk=%b ovr=%b st=%0d need v=%b d=%h pe=%b fe=%b brk=%b ovr=%b st=%0d",
                 $time, rx_valid, rx_data, parity_error, framing_error, break_int, overrun, rstate,
                 e_valid, e_data, e_pe, e_fe, e_brk, e_ovr, exp_state());
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h need %0h", name, act, exp);
    end
  endtask

  task automatic line(input logic v, input int ticks);
    srx_pad_i = v;
    repeat (ticks * DIV) @(negedge clk);
  endtask

  task automatic idle_bits(input int n);
    line(1'b1, 16 * n);
  endtask

  task automatic send_frame(input logic [7:0] d, input int nb, input bit has_par,
                            input logic par, input logic stop);
    line(1'b0, 16);
    for (int i = 0; i < nb; i++) line(d[i], 16);
    if (has_par) line(par, 16);
    line(stop, 16);
    srx_pad_i = 1'b1;
  endtask

  task automatic pop();
    rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
    @(negedge clk);
  endtask

  task automatic rd_at_push();
    for (int i = 0; i < 20 * BIT_CLKS && rstate != 3'd5; i++) @(negedge clk);
    check("push_reached", {29'd0, rstate}, 32'd5);
    rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
  endtask

  task automatic check_flags(input string name, input logic [3:0] need);
    check(name, {28'd0, parity_error, framing_error, break_int, overrun}, {28'd0, need});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    srx_pad_i = 1'b1;
    rd        = 1'b0;
    lcr       = 8'h03;
    wb_rst_i  = 1'b0;
    repeat (4) @(negedge clk);
    m_on = 1'b1;
    check("rst_valid", {31'd0, rx_valid}, 32'd0);
    check("rst_data", {24'd0, rx_data}, 32'd0);
    check("rst_state", {29'd0, rstate}, 32'd0);
    check_flags("rst_flags", 4'b0000);
    wb_rst_i = 1'b1;
    idle_bits(1);

    send_frame(8'h55, 8, 1'b0, 1'b0, 1'b1);
    idle_bits(1);
    check("8n1_data", {24'd0, rx_data}, 32'h55);
    check("8n1_valid", {31'd0, rx_valid}, 32'd1);
    check_flags("8n1_flags", 4'b0000);
    pop();
    check("pop_valid", {31'd0, rx_valid}, 32'd0);
    check("pop_keeps_data", {24'd0, rx_data}, 32'h55);

    lcr = 8'h1A;
    send_frame(8'h41, 7, 1'b1, 1'b1, 1'b1);
    idle_bits(1);
    check("7e1_bad_data", {24'd0, rx_data}, 32'h41);
    check_flags("7e1_bad_flags", 4'b1000);
    pop();
    send_frame(8'h41, 7, 1'b1, 1'b0, 1'b1);
    idle_bits(1);
    check("7e1_good_data", {24'd0, rx_data}, 32'h41);
    check_flags("7e1_good_flags", 4'b0000);
    pop();

    lcr = 8'h28;
    send_frame(8'hFF, 5, 1'b1, 1'b0, 1'b1);
    idle_bits(1);
    check("5bit_stick_data", {24'd0, rx_data}, 32'h1F);
    check_flags("5bit_stick_flags", 4'b1000);
    pop();

    lcr = 8'h03;
    line(1'b0, 4);
    idle_bits(2);
    check("glitch_valid", {31'd0, rx_valid}, 32'd0);
    check("glitch_state", {29'd0, rstate}, 32'd0);

    srx_pad_i = 1'b0;
    repeat (11 * BIT_CLKS) @(negedge clk);
    check("break_wait_state", {29'd0, rstate}, 32'd6);
    repeat (BIT_CLKS) @(negedge clk);
    srx_pad_i = 1'b1;
    repeat (4) @(negedge clk);
    check("break_idle_state", {29'd0, rstate}, 32'd0);
    check("break_data", {24'd0, rx_data}, 32'h00);
    check_flags("break_flags", 4'b0110);
    pop();

    send_frame(8'h11, 8, 1'b0, 1'b0, 1'b1);
    idle_bits(1);
    send_frame(8'h22, 8, 1'b0, 1'b0, 1'b1);
    idle_bits(1);
    check("ovr_data", {24'd0, rx_data}, 32'h11);
    check_flags("ovr_flags", 4'b0001);
    pop();
    check("ovr_pop_valid", {31'd0, rx_valid}, 32'd0);
    check_flags("ovr_pop_flags", 4'b0000);
    send_frame(8'h11, 8, 1'b0, 1'b0, 1'b1);
    idle_bits(1);
    fork
      send_frame(8'h22, 8, 1'b0, 1'b0, 1'b1);
      rd_at_push();
    join
    idle_bits(1);
    check("rdpush_data", {24'd0, rx_data}, 32'h22);
    check("rdpush_valid", {31'd0, rx_valid}, 32'd1);
    check_flags("rdpush_flags", 4'b0000);

    fork
      send_frame(8'h5A, 8, 1'b0, 1'b0, 1'b1);
      begin
        repeat (4 * BIT_CLKS + 8 * DIV) @(negedge clk);
        wb_rst_i = 1'b0;
      end
    join
    check("midrst_valid", {31'd0, rx_valid}, 32'd0);
    check("midrst_data", {24'd0, rx_data}, 32'd0);
    check("midrst_state", {29'd0, rstate}, 32'd0);
    check_flags("midrst_flags", 4'b0000);
    wb_rst_i = 1'b1;
    idle_bits(1);
    send_frame(8'h3C, 8, 1'b0, 1'b0, 1'b1);
    idle_bits(1);
    check("after_rst_data", {24'd0, rx_data}, 32'h3C);
    check("after_rst_valid", {31'd0, rx_valid}, 32'd1);
    pop();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
